filter_scheduler: RTL and testbench
===================================

FILTER_SCHEDULER -- requirements
Module: filter_scheduler

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of filtered input channels (range 2..8).
REQ-002 The block SHALL have parameter PRESCALE, default 8, giving clock cycles per sample tick (minimum N_CH+2).
REQ-003 The block SHALL have port clock  input  1  rising-edge system clock.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port sig_in  input  N_CH  raw asynchronous-free channel inputs.
REQ-006 The block SHALL have port sig_out  output  N_CH  filtered channel outputs, registered.
REQ-007 The block SHALL have port chan  output  3  index of the channel being processed, valid while busy.
REQ-008 The block SHALL have port busy  output  1  high during SCAN and DONE states.
REQ-009 The block SHALL have port scan_done  output  1  single-cycle pulse after the last channel is processed.
REQ-010 The block SHALL have port overrun  output  1  sticky flag, a tick arrived while busy.

Function
REQ-011 The block SHALL run a free-running prescale counter 0..PRESCALE-1; tick is asserted in the cycle the counter equals PRESCALE-1.
REQ-012 The block SHALL implement the FSM IDLE -> SCAN -> DONE -> IDLE; IDLE->SCAN on tick, SCAN->DONE after channel N_CH-1, DONE->IDLE unconditionally.
REQ-013 On the tick cycle in IDLE, the block SHALL snapshot sig_in into snap and load chan=0; all channels use that snapshot.
REQ-014 In SCAN, the block SHALL process exactly one channel per cycle, chan incrementing 0..N_CH-1, with no wrap.
REQ-015 Processing channel c SHALL form h = {snap[c], hist[c][2:1]}, write it to 3-bit hist[c], and compute j = &h, k = ~|h.
REQ-016 sig_out[c] SHALL update per JK: j=1 sets it to 1, k=1 clears it to 0, otherwise holds; it is visible the cycle after channel c is processed.
REQ-017 Channels not being processed SHALL hold hist and sig_out unchanged.
REQ-018 scan_done SHALL be high only in the DONE cycle; tick-to-scan_done latency is N_CH+1 cycles.
REQ-019 A tick arriving while busy SHALL be dropped, not queued, and SHALL set overrun; overrun clears only on reset.
REQ-020 A tick in the DONE cycle SHALL count as an overrun (dropped).

Reset
REQ-021 When reset=0 at a rising edge, the block SHALL clear the prescale counter, hist, snap, sig_out, chan, overrun and scan_done, and enter IDLE.
REQ-022 Reset asserted mid-scan SHALL abort the scan with no further channel updates and no scan_done pulse.
REQ-023 After reset release, the first tick SHALL occur PRESCALE cycles later.

Configuration
REQ-024 With macro FILTER_SCHED_IRQ_EN defined, the block SHALL add ports irq (output, 1) and irq_ack (input, 1).
REQ-025 With FILTER_SCHED_IRQ_EN, irq SHALL set in the DONE cycle if any sig_out bit changed during that scan, and SHALL clear the cycle after irq_ack=1; a set in the same cycle as an ack SHALL win.
REQ-026 Without FILTER_SCHED_IRQ_EN, irq and irq_ack SHALL be absent and behaviour SHALL be otherwise identical.

Verification (N_CH=4, PRESCALE=8)
REQ-027 Reset, then hold sig_in=4'b0000 for 5 ticks -> sig_out stays 0000, scan_done pulses every 8 cycles, 5 cycles after each tick.
REQ-028 sig_in=4'b0101 held for 3 ticks -> sig_out=0101 after the 3rd scan, bit0 updating one cycle before bit2.
REQ-029 Channel 1 toggles 1,0,1,1,1 on successive ticks from sig_out=0 -> sig_out[1] stays 0 through 4 ticks and rises after the 5th.
REQ-030 Reset pulsed low during SCAN with chan=2 -> no scan_done, sig_out=0000, overrun=0, next tick 8 cycles after release.
REQ-031 Force tick while busy (PRESCALE=5 build) -> tick dropped, overrun=1 and stays 1 until reset.
REQ-032 With FILTER_SCHED_IRQ_EN, sig_out changes 0000->0001 -> irq=1 in the DONE cycle; irq_ack=1 -> irq=0 next cycle; scan with no change -> irq stays 0.

Source files
------------

// File: rtl/filter_scheduler.sv
// -----------------------------------------------------------------------------
// filter_scheduler
//
// Time-multiplexed glitch filter for N_CH slow digital inputs. A free-running
// prescaler produces a sample tick every PRESCALE cycles. On a tick the inputs
// are snapshotted, then one channel per cycle is pushed through a 3-deep
// history and a JK output stage:
//   - three consecutive ones set the output;
//   - three consecutive zeros clear it;
//   - anything else holds it.
//
// Parameters
//   N_CH      number of channels (2..8)
//   PRESCALE  clock cycles per sample tick (>= N_CH+2 for drop-free scans)
//
// Ports
//   clock      in   rising-edge system clock
//   reset      in   synchronous, active-low reset
//   sig_in     in   [N_CH] raw channel inputs
//   sig_out    out  [N_CH] filtered channel outputs (registered)
//   chan       out  [3]    channel being processed, valid while busy
//   busy       out         high during SCAN and DONE
//   scan_done  out         one-cycle pulse in the DONE state
//   overrun    out         sticky: a tick arrived while busy (cleared by reset)
//
// Optional feature, enabled by defining FILTER_SCHED_IRQ_EN:
//   irq        out         set in DONE when any sig_out bit changed during the scan
//   irq_ack    in          clears irq on the following cycle (a set wins)
// -----------------------------------------------------------------------------
module filter_scheduler #(
  parameter int N_CH     = 4,
  parameter int PRESCALE = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] sig_in,
  output logic [N_CH-1:0] sig_out,
  output logic [2:0]      chan,
  output logic            busy,
  output logic            scan_done,
  output logic            overrun
`ifdef FILTER_SCHED_IRQ_EN
  ,
  output logic            irq,
  input  logic            irq_ack
`endif
);

  localparam int               CNT_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       CHAN_LAST = 3'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [N_CH-1:0]        snap_r;
  logic [N_CH-1:0][2:0]   hist_r;
  logic [N_CH-1:0]        sig_out_r;
  logic [2:0]             chan_r;
  logic                   busy_r;
  logic                   scan_done_r;
  logic                   overrun_r;

  logic                   tick_s;
  logic                   last_s;
  logic [N_CH-1:0][2:0]   h_s;
  logic [N_CH-1:0]        next_out_s;
  logic [N_CH-1:0]        sel_s;

`ifdef FILTER_SCHED_IRQ_EN
  logic                   irq_r;
  logic                   chg_r;
  logic                   change_s;
`endif

  // JK output stage: all-ones history sets, all-zeros history clears, else hold.
  function automatic logic jk_next(input logic [2:0] h, input logic q);
    logic j;
    logic k;
    j = &h;
    k = ~|h;
    if (j) begin
      return 1'b1;
    end else if (k) begin
      return 1'b0;
    end else begin
      return q;
    end
  endfunction

  // Tick decode and last-channel decode.
  always_comb begin
    tick_s = (cnt_r == CNT_MAX);
    last_s = (chan_r == CHAN_LAST);
  end

  // Per-channel history shift and next output. Only the channel under the scan
  // pointer is enabled, so every other channel holds its state.
  always_comb begin
    h_s        = {N_CH{3'b000}};
    next_out_s = {N_CH{1'b0}};
    sel_s      = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      h_s[c]        = {snap_r[c], hist_r[c][2:1]};
      next_out_s[c] = jk_next(h_s[c], sig_out_r[c]);
      sel_s[c]      = (state_r == ST_SCAN) && (chan_r == 3'(c));
    end
  end

`ifdef FILTER_SCHED_IRQ_EN
  // Output change caused by the channel processed this cycle.
  always_comb begin
    change_s = |(sel_s & (next_out_s ^ sig_out_r));
  end
`endif

  // Prescaler, scan FSM, per-channel filter state and status flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r       <= CNT_ZERO;
      state_r     <= ST_IDLE;
      snap_r      <= {N_CH{1'b0}};
      hist_r      <= {N_CH{3'b000}};
      sig_out_r   <= {N_CH{1'b0}};
      chan_r      <= 3'd0;
      busy_r      <= 1'b0;
      scan_done_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef FILTER_SCHED_IRQ_EN
      irq_r       <= 1'b0;
      chg_r       <= 1'b0;
`endif
    end else begin
      if (tick_s) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end

      scan_done_r <= 1'b0;

`ifdef FILTER_SCHED_IRQ_EN
      // Ack clears first so that a set later in this block takes priority.
      if (irq_ack) begin
        irq_r <= 1'b0;
      end
`endif

      case (state_r)
        ST_IDLE: begin
          if (tick_s) begin
            snap_r  <= sig_in;
            chan_r  <= 3'd0;
            busy_r  <= 1'b1;
            state_r <= ST_SCAN;
`ifdef FILTER_SCHED_IRQ_EN
            chg_r   <= 1'b0;
`endif
          end
        end
        ST_SCAN: begin
          // Ticks during a scan are dropped, never queued.
          if (tick_s) begin
            overrun_r <= 1'b1;
          end
`ifdef FILTER_SCHED_IRQ_EN
          chg_r <= chg_r | change_s;
`endif
          if (last_s) begin
            // chan stays on the last channel: no wrap back to 0.
            state_r     <= ST_DONE;
            scan_done_r <= 1'b1;
`ifdef FILTER_SCHED_IRQ_EN
            if (chg_r || change_s) begin
              irq_r <= 1'b1;
            end
`endif
          end else begin
            chan_r <= chan_r + 3'd1;
          end
        end
        ST_DONE: begin
          if (tick_s) begin
            overrun_r <= 1'b1;
          end
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase

      for (int c = 0; c < N_CH; c++) begin
        if (sel_s[c]) begin
          hist_r[c]    <= h_s[c];
          sig_out_r[c] <= next_out_s[c];
        end
      end
    end
  end

  assign sig_out   = sig_out_r;
  assign chan      = chan_r;
  assign busy      = busy_r;
  assign scan_done = scan_done_r;
  assign overrun   = overrun_r;
`ifdef FILTER_SCHED_IRQ_EN
  assign irq       = irq_r;
`endif

endmodule

// File: tb/tb_filter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_filter_scheduler
//
// Table-driven bench for filter_scheduler (N_CH=4, PRESCALE=8), plus a second
// instance built with PRESCALE=5 so that a tick lands in the DONE cycle.
// Hand-written sequences cover the per-channel update order, input snapshot,
// reset in the middle of a scan, sticky overrun and, when FILTER_SCHED_IRQ_EN
// is defined, the irq/irq_ack handshake.
// -----------------------------------------------------------------------------
module tb_filter_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] sig_in;
  logic [3:0] sig_out;
  logic [2:0] chan;
  logic       busy;
  logic       scan_done;
  logic       overrun;

  logic [3:0] o_sig_out;
  logic [2:0] o_chan;
  logic       o_busy;
  logic       o_scan_done;
  logic       o_overrun;

`ifdef FILTER_SCHED_IRQ_EN
  logic       irq;
  logic       irq_ack;
  logic       o_irq;
  logic       o_irq_ack;
`endif

  int errors;
  int checks;
  int cyc;
  int reset_cyc;
  int done_at;
  int exp_done;

  typedef struct {
    logic [3:0] sin;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs[16];

  filter_scheduler #(.N_CH(4), .PRESCALE(8)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .chan      (chan),
    .busy      (busy),
    .scan_done (scan_done),
    .overrun   (overrun)
`ifdef FILTER_SCHED_IRQ_EN
    ,
    .irq       (irq),
    .irq_ack   (irq_ack)
`endif
  );

  filter_scheduler #(.N_CH(4), .PRESCALE(5)) u_ovr (
    .clock     (clock),
    .reset     (reset),
    .sig_in    (sig_in),
    .sig_out   (o_sig_out),
    .chan      (o_chan),
    .busy      (o_busy),
    .scan_done (o_scan_done),
    .overrun   (o_overrun)
`ifdef FILTER_SCHED_IRQ_EN
    ,
    .irq       (o_irq),
    .irq_ack   (o_irq_ack)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Two reset edges; reset_cyc is the last edge that saw reset low.
  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset_cyc = cyc;
    reset = 1'b1;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int n = 0; n < 30; n++) begin
      step();
      if (scan_done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected scan_done pulse (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_busy();
    int seen;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (busy === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) begin
      checks++;
      errors++;
      $display("FAIL wait_busy: got timeout expected busy rise (cycle %0d)", cyc);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    reset     = 1'b0;
    sig_in    = 4'b0000;
`ifdef FILTER_SCHED_IRQ_EN
    irq_ack   = 1'b0;
    o_irq_ack = 1'b0;
`endif

    // Idle zeros, then 0101 held, then channel 1 toggling 1,0,1,1,1 on top of
    // 0101, then zeros again: outputs hold for two scans and clear on the third.
    vecs[0]  = '{4'b0000, 4'b0000};
    vecs[1]  = '{4'b0000, 4'b0000};
    vecs[2]  = '{4'b0000, 4'b0000};
    vecs[3]  = '{4'b0000, 4'b0000};
    vecs[4]  = '{4'b0000, 4'b0000};
    vecs[5]  = '{4'b0101, 4'b0000};
    vecs[6]  = '{4'b0101, 4'b0000};
    vecs[7]  = '{4'b0101, 4'b0101};
    vecs[8]  = '{4'b0111, 4'b0101};
    vecs[9]  = '{4'b0101, 4'b0101};
    vecs[10] = '{4'b0111, 4'b0101};
    vecs[11] = '{4'b0111, 4'b0101};
    vecs[12] = '{4'b0111, 4'b0111};
    vecs[13] = '{4'b0000, 4'b0111};
    vecs[14] = '{4'b0000, 4'b0111};
    vecs[15] = '{4'b0000, 4'b0000};

    // ---------------- reset state ----------------
    do_reset();
    check("rst_sig_out",   32'(sig_out),   32'h0);
    check("rst_chan",      32'(chan),      32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_scan_done", 32'(scan_done), 32'h0);
    check("rst_overrun",   32'(overrun),   32'h0);
    check("rst_o_overrun", 32'(o_overrun), 32'h0);

    // ---------------- table-driven scans ----------------
    // First tick is acted on 8 edges after reset, scan_done 4 edges later.
    exp_done = reset_cyc + 12;
    sig_in   = vecs[0].sin;
    for (int i = 0; i < 16; i++) begin
      wait_done(done_at);
      check($sformatf("v%0d_done_cycle", i), 32'(done_at), 32'(exp_done));
      check($sformatf("v%0d_sig_out", i),    32'(sig_out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d_busy", i),       32'(busy),    32'h1);
      step();
      check($sformatf("v%0d_done_pulse", i), 32'(scan_done), 32'h0);
      check($sformatf("v%0d_busy_off", i),   32'(busy),      32'h0);
      if (i < 15) begin
        sig_in = vecs[i + 1].sin;
      end else begin
        sig_in = 4'b0000;
      end
      exp_done = exp_done + 8;
    end
    check("tbl_overrun", 32'(overrun), 32'h0);

    // ---------------- channel order and snapshot ----------------
    do_reset();
    sig_in = 4'b1111;
    wait_done(done_at);
    check("ord_scan1", 32'(sig_out), 32'h0);
    wait_done(done_at);
    check("ord_scan2", 32'(sig_out), 32'h0);
    wait_busy();
    check("ord_chan0", 32'(chan),    32'h0);
    check("ord_out0",  32'(sig_out), 32'h0);
    sig_in = 4'b0000;  // after the snapshot: must not affect this scan
    step();
    check("ord_chan1", 32'(chan),    32'h1);
    check("ord_out1",  32'(sig_out), 32'h1);
    step();
    check("ord_chan2", 32'(chan),    32'h2);
    check("ord_out2",  32'(sig_out), 32'h3);
    step();
    check("ord_chan3", 32'(chan),    32'h3);
    check("ord_out3",  32'(sig_out), 32'h7);
    step();
    check("ord_done",      32'(scan_done), 32'h1);
    check("ord_out_final", 32'(sig_out),   32'hf);
    check("ord_chan_hold", 32'(chan),      32'h3);

    // ---------------- reset in the middle of a scan ----------------
    wait_busy();
    step();
    step();
    check("mid_chan2", 32'(chan), 32'h2);
    reset = 1'b0;
    step();
    reset_cyc = cyc;
    reset = 1'b1;
    check("mid_sig_out",   32'(sig_out),   32'h0);
    check("mid_busy",      32'(busy),      32'h0);
    check("mid_scan_done", 32'(scan_done), 32'h0);
    check("mid_chan",      32'(chan),      32'h0);
    check("mid_overrun",   32'(overrun),   32'h0);
    for (int i = 1; i < 8; i++) begin
      step();
      check($sformatf("mid_quiet%0d", i), 32'({busy, scan_done}), 32'h0);
    end
    step();
    check("mid_next_tick", 32'(busy), 32'h1);
    check("mid_next_chan", 32'(chan), 32'h0);

    // ---------------- overrun with PRESCALE=5 ----------------
    do_reset();
    while (cyc < reset_cyc + 9) begin
      step();
    end
    check("ovr_done",       32'(o_scan_done), 32'h1);
    check("ovr_before",     32'(o_overrun),   32'h0);
    step();
    check("ovr_set",        32'(o_overrun),   32'h1);
    check("ovr_dropped",    32'(o_busy),      32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
    end
    check("ovr_next_scan",  32'(o_busy),      32'h1);
    for (int i = 0; i < 30; i++) begin
      step();
    end
    check("ovr_sticky",     32'(o_overrun),   32'h1);
    check("ovr_main_clean", 32'(overrun),     32'h0);
    do_reset();
    check("ovr_cleared",    32'(o_overrun),   32'h0);

`ifdef FILTER_SCHED_IRQ_EN
    // ---------------- irq handshake ----------------
    do_reset();
    check("irq_rst", 32'(irq), 32'h0);
    sig_in = 4'b0001;
    wait_done(done_at);
    check("irq_scan1", 32'(irq), 32'h0);
    wait_done(done_at);
    check("irq_scan2", 32'(irq), 32'h0);
    wait_done(done_at);
    check("irq_out",   32'(sig_out), 32'h1);
    check("irq_set",   32'(irq),     32'h1);
    irq_ack = 1'b1;
    step();
    check("irq_ack_clr", 32'(irq), 32'h0);
    irq_ack = 1'b0;
    wait_done(done_at);
    check("irq_nochange", 32'(irq), 32'h0);
    // Ack held high across a scan that changes an output: the set wins.
    sig_in  = 4'b0000;
    irq_ack = 1'b1;
    wait_done(done_at);
    wait_done(done_at);
    wait_done(done_at);
    check("irq_win_out", 32'(sig_out), 32'h0);
    check("irq_win_set", 32'(irq),     32'h1);
    step();
    check("irq_win_clr", 32'(irq),     32'h0);
    irq_ack = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
